wb_arbiter2: RTL and testbench
==============================

# wb_arbiter2

Two-master Wishbone classic arbiter that shares the single 32-bit word-addressed system bus (text and data memories) between the core's instruction-fetch port (m0) and load/store port (m1). It sits between the core and the memory decode logic. It grants whole bus cycles (a `cyc` envelope) round-robin, forwards the owner's signals to the slave, and routes `ack` back. A watchdog terminates stalled transfers with an error pulse.

## Interface

- `TIMEOUT`, default 255: cycles a granted strobe may wait for `ack` before error termination; 0 disables the watchdog.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master-0 (fetch) cycle, strobe, write enable.
- `m0_sel_i`  in  4  master-0 byte selects.
- `m0_adr_i`  in  30  master-0 word address.
- `m0_dat_i`  in  32  master-0 write data.
- `m0_ack_o`, `m0_err_o`  out  1 each  master-0 acknowledge and error.
- `m0_dat_o`  out  32  master-0 read data.
- `m1_*`: same set as m0, for the load/store master.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  slave cycle, strobe, write enable.
- `s_sel_o`  out  4  slave byte selects.
- `s_adr_o`  out  30  slave word address.
- `s_dat_o`  out  32  slave write data.
- `s_ack_i`  in  1  slave acknowledge.
- `s_dat_i`  in  32  slave read data.

## Operation

- FSM states: IDLE, GNT0, GNT1. A `last` register holds the most recently granted master. A watchdog counter `wd` has width clog2(TIMEOUT+1).
- IDLE: if only one `mX_cyc_i` is high, go to GNTX. If both are high, grant the master that is not `last`. Update `last` on every grant.
- GNTX while `mX_cyc_i` is high: stay in GNTX. The arbiter never pre-empts a granted master.
- GNTX when `mX_cyc_i` is low: if the other master's `cyc` is high, go directly to its GNT state and update `last`. Otherwise go to IDLE.
- Slave outputs in GNTX: combinational copy of master X's `cyc/stb/we/sel/adr/dat`. In IDLE: all zero.
- `s_dat_i` is driven to both `m0_dat_o` and `m1_dat_o`. `mX_ack_o` = `s_ack_i` AND state==GNTX AND not watchdog-expired. The non-owner's ack is always 0.
- Watchdog: in GNTX with `s_stb_o` high and `s_ack_i` low, `wd` increments. It clears on `ack`, on a state change, or when `stb` is low.
- When `wd`==TIMEOUT (and TIMEOUT≠0): `mX_err_o`=1 for that cycle, `s_stb_o` is forced to 0 that cycle, and `wd` clears. Grant is kept; the master decides whether to drop `cyc`.
- `err` and `ack` are never both high to the same master.

## Timing

- Reset values: state IDLE, `last`=m1 (so m0 wins the first tie), `wd`=0. All `s_*` outputs 0, all `m*_ack_o`/`m*_err_o` 0. `m*_dat_o` follow `s_dat_i`.
- Arbitration latency: 1 cycle from `cyc` rising in IDLE to the bus being forwarded. With a zero-wait slave, a single access takes 2 cycles from request.
- Handover: owner `cyc` drops in cycle N; the other master is forwarded in cycle N+1. There are no idle bubbles.
- Ack path is combinational `s_ack_i` → `mX_ack_o`, with zero added latency. Back-to-back strobes within one `cyc` sustain 1 transfer/cycle.
- Simultaneous requests from IDLE are resolved by `last` only. A master that raises `cyc` in the same cycle as the owner's `cyc` drops is treated as requesting.
- Reset asserted mid-transfer: outputs go to 0 immediately (asynchronous). After deassertion, the FSM restarts in IDLE with `last`=m1.

## Structure

- Package `wb_arb_pkg` holds `typedef enum {IDLE, GNT0, GNT1} arb_state_t` and the Wishbone width constants (`WB_ADR_W`=30, `WB_DAT_W`=32, `WB_SEL_W`=4).
- Sub-module `wb_watchdog` (parameter TIMEOUT; inputs: clear, count enable; output: expire) contains the counter. The arbiter holds the FSM and the muxes.

## Test plan

- Reset: hold `rst`=0 with both `cyc`=1 → all `s_*`=0, no acks. Release reset → GNT0 next cycle, `s_adr_o`=`m0_adr_i`.
- Contention: both masters hold `cyc` for 3 single-beat transfers each against a zero-wait slave → grants alternate m0,m1,m0,… with no idle cycle between owners. The non-owner's ack stays 0.
- Burst hold: m1 keeps `cyc` high for 4 strobes while m0 requests → m1 gets 4 acks in 4 consecutive cycles, then m0 is granted the cycle after m1's `cyc` drops.
- Write path: m1 writes `sel`=4'b0101, `dat`=32'hA5A5_1234 at `adr`=30'h2000_0010 → slave sees identical values and `we`=1 while `m0_we_i`=0.
- Watchdog: TIMEOUT=4, slave never acks m0 → `m0_err_o` pulses on the 5th strobe cycle with `s_stb_o`=0 in that cycle. A later ack succeeds normally.
- TIMEOUT=0: stall 1000 cycles → no `err`, and the grant is held throughout.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master Wishbone arbiter:
//   - Wishbone bus widths (word address, data, byte selects)
//   - arbiter FSM state encoding
// ---------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_watchdog.sv
// ---------------------------------------------------------------------------
// wb_watchdog
// Counts cycles a granted strobe has been waiting for an acknowledge and
// flags expiry when the count reaches TIMEOUT. TIMEOUT = 0 disables it.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-low reset
//   clr     in  clear the counter this cycle (wins over cnt_en)
//   cnt_en  in  count this cycle
//   expire  out count has reached TIMEOUT (counter clears on the next edge)
// ---------------------------------------------------------------------------
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    output logic expire
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT);
    localparam bit ENABLED = (TIMEOUT != 0);

    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;

    assign expire = ENABLED && (wd_q == LIMIT);

    always_comb begin
        wd_d = wd_q;
        if (clr || expire) begin
            wd_d = '0;
        end else if (cnt_en && ENABLED) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// ---------------------------------------------------------------------------
// wb_arbiter2
// Two-master Wishbone classic arbiter. Whole cyc envelopes are granted
// round-robin (m0 = instruction fetch, m1 = load/store); the owner's bus is
// forwarded combinationally to the slave and the slave ack is routed back.
// A watchdog ends a stalled strobe with a one-cycle error pulse.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   mX_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i   master X request
//   mX_ack_o/err_o/dat_o             master X response
//   s_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o    slave request
//   s_ack_i, s_dat_i                 slave response
// ---------------------------------------------------------------------------
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    input  logic [WB_ADR_W-1:0] m0_adr_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    output logic [WB_DAT_W-1:0] m0_dat_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    input  logic [WB_ADR_W-1:0] m1_adr_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic [WB_DAT_W-1:0] m1_dat_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [WB_SEL_W-1:0] s_sel_o,
    output logic [WB_ADR_W-1:0] s_adr_o,
    output logic [WB_DAT_W-1:0] s_dat_o,
    input  logic                s_ack_i,
    input  logic [WB_DAT_W-1:0] s_dat_i
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;   // most recently granted master: 0 = m0, 1 = m1

    logic own0, own1;
    logic own_stb;
    logic wd_clr, wd_cnt_en, wd_expire;

    // Next-state: an owner is never pre-empted; when it drops cyc the other
    // master (if requesting) is handed the bus directly without passing IDLE.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_d == GNT0) && (state_q != GNT0)) begin
            last_d = 1'b0;
        end
        if ((state_d == GNT1) && (state_q != GNT1)) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign own0 = (state_q == GNT0);
    assign own1 = (state_q == GNT1);

    // Bus forwarding and response routing. On watchdog expiry the strobe is
    // withheld from the slave and any ack is suppressed so that err and ack
    // never reach the owner together.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        own_stb  = 1'b0;
        if (own0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i && !wd_expire;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            own_stb = m0_stb_i;
        end else if (own1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i && !wd_expire;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            own_stb = m1_stb_i;
        end
    end

    assign m0_ack_o = own0 && s_ack_i && !wd_expire;
    assign m1_ack_o = own1 && s_ack_i && !wd_expire;
    assign m0_err_o = own0 && wd_expire;
    assign m1_err_o = own1 && wd_expire;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // The wait count only survives cycles where the same owner keeps a
    // strobe outstanding without an ack; anything else restarts it.
    assign wd_cnt_en = (own0 || own1) && own_stb && !s_ack_i;
    assign wd_clr    = !wd_cnt_en || (state_d != state_q);

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .cnt_en (wd_cnt_en),
        .expire (wd_expire)
    );

endmodule

// File: tb/tb_wb_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter2
// Two arbiters share the same master stimulus: u_dut_a with TIMEOUT=4 and
// u_dut_b with the watchdog disabled. Each has its own zero-wait slave whose
// readiness the bench controls. A behavioural model of the arbitration
// policy is checked against both DUTs on every falling edge, and directed
// phases add literal expectations.
// ---------------------------------------------------------------------------
module tb_wb_arbiter2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // master side (shared by both DUTs)
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic [29:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [31:0] s_rdat;
    logic        ready;

    // per-DUT outputs, index 0 = TIMEOUT 4, index 1 = TIMEOUT 0
    logic        s_cyc [2];
    logic        s_stb [2];
    logic        s_we  [2];
    logic [3:0]  s_sel [2];
    logic [29:0] s_adr [2];
    logic [31:0] s_wdat[2];
    logic        s_ack [2];
    logic        ack0  [2];
    logic        ack1  [2];
    logic        err0  [2];
    logic        err1  [2];
    logic [31:0] rd0   [2];
    logic [31:0] rd1   [2];

    assign s_ack[0] = s_stb[0] & ready;
    assign s_ack[1] = s_stb[1] & ready;

    wb_arbiter2 #(.TIMEOUT(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
        .m0_sel_i(m_sel[0]), .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]),
        .m0_ack_o(ack0[0]), .m0_err_o(err0[0]), .m0_dat_o(rd0[0]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
        .m1_sel_i(m_sel[1]), .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]),
        .m1_ack_o(ack1[0]), .m1_err_o(err1[0]), .m1_dat_o(rd1[0]),
        .s_cyc_o(s_cyc[0]), .s_stb_o(s_stb[0]), .s_we_o(s_we[0]),
        .s_sel_o(s_sel[0]), .s_adr_o(s_adr[0]), .s_dat_o(s_wdat[0]),
        .s_ack_i(s_ack[0]), .s_dat_i(s_rdat)
    );

    wb_arbiter2 #(.TIMEOUT(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
        .m0_sel_i(m_sel[0]), .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]),
        .m0_ack_o(ack0[1]), .m0_err_o(err0[1]), .m0_dat_o(rd0[1]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
        .m1_sel_i(m_sel[1]), .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]),
        .m1_ack_o(ack1[1]), .m1_err_o(err1[1]), .m1_dat_o(rd1[1]),
        .s_cyc_o(s_cyc[1]), .s_stb_o(s_stb[1]), .s_we_o(s_we[1]),
        .s_sel_o(s_sel[1]), .s_adr_o(s_adr[1]), .s_dat_o(s_wdat[1]),
        .s_ack_i(s_ack[1]), .s_dat_i(s_rdat)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_n  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: owner (-1 = nobody), last granted, wait count
    // ------------------------------------------------------------------
    int own [2];
    int lst [2];
    int wt  [2];
    int tmo [2];

    function automatic logic model_expired(int k);
        return (own[k] >= 0) && (tmo[k] != 0) && (wt[k] == tmo[k]);
    endfunction

    function automatic logic model_ack(int k);
        int o;
        o = own[k];
        if (o < 0) return 1'b0;
        return m_stb[o] && !model_expired(k) && ready;
    endfunction

    initial begin
        tmo[0] = 4;
        tmo[1] = 0;
        for (int k = 0; k < 2; k++) begin
            own[k] = -1; lst[k] = 1; wt[k] = 0;
        end
        forever begin
            @(posedge clk or negedge rst);
            for (int k = 0; k < 2; k++) begin
                if (!rst) begin
                    own[k] = -1; lst[k] = 1; wt[k] = 0;
                end else begin
                    int  o, n;
                    logic ex, ak;
                    o  = own[k];
                    ex = model_expired(k);
                    ak = model_ack(k);
                    n  = o;
                    if (o >= 0) begin
                        if (!m_cyc[o]) n = m_cyc[1-o] ? 1 - o : -1;
                    end else if (m_cyc[0] && m_cyc[1]) begin
                        n = 1 - lst[k];
                    end else if (m_cyc[0]) begin
                        n = 0;
                    end else if (m_cyc[1]) begin
                        n = 1;
                    end
                    if (n >= 0 && n != o) lst[k] = n;
                    if (!ex && o >= 0 && n == o && m_stb[o] && !ak) wt[k] = wt[k] + 1;
                    else wt[k] = 0;
                    own[k] = n;
                end
            end
        end
    end

    // compare process: every falling edge, both DUTs
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int o;
                logic ex, ak;
                logic [68:0] eb;
                o  = own[k];
                ex = model_expired(k);
                ak = model_ack(k);
                eb = '0;
                if (o >= 0) eb = {m_cyc[o], m_stb[o] & ~ex, m_we[o], m_sel[o], m_adr[o], m_dat[o]};
                chk($sformatf("model_bus%0d", k),
                    {s_cyc[k], s_stb[k], s_we[k], s_sel[k], s_adr[k], s_wdat[k]}, eb);
                chk($sformatf("model_resp%0d", k), {ack0[k], ack1[k], err0[k], err1[k]},
                    {o == 0 && ak, o == 1 && ak, o == 0 && ex, o == 1 && ex});
                chk($sformatf("model_rdata%0d", k), {rd0[k], rd1[k]}, {s_rdat, s_rdat});
            end
        end
    end

    // ------------------------------------------------------------------
    // Master BFM: txn envelopes each of blen beats; reacts to DUT A acks
    // ------------------------------------------------------------------
    int txn  [2];
    int blen [2];
    int bl   [2];
    logic seen [2];

    initial begin
        forever begin
            @(negedge clk);
            seen[0] = ack0[0];
            seen[1] = ack1[0];
            @(posedge clk);
            cyc_n++;
            #1;
            s_rdat = 32'hD000_0000 + 32'(cyc_n);
            for (int i = 0; i < 2; i++) begin
                if (m_cyc[i]) begin
                    if (seen[i]) begin
                        bl[i]--;
                        if (bl[i] == 0) begin
                            m_cyc[i] = 1'b0;
                            m_stb[i] = 1'b0;
                            txn[i]--;
                        end
                    end
                end else if (txn[i] > 0) begin
                    m_cyc[i] = 1'b1;
                    m_stb[i] = 1'b1;
                    bl[i]    = blen[i];
                end
            end
        end
    end

    // one line per acknowledged transfer (DUT A)
    int ack_who  [$];
    int ack_when [$];
    initial begin
        forever begin
            @(negedge clk);
            if (ack0[0]) begin
                ack_who.push_back(0); ack_when.push_back(cyc_n);
                $display("txn m0 ack cycle %0d adr=%0h", cyc_n, s_adr[0]);
            end
            if (ack1[0]) begin
                ack_who.push_back(1); ack_when.push_back(cyc_n);
                $display("txn m1 ack cycle %0d adr=%0h we=%0b", cyc_n, s_adr[1], s_we[0]);
            end
        end
    end

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while ((txn[0] != 0 || txn[1] != 0 || m_cyc[0] || m_cyc[1]) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_in_time"}, t < 300, 1'b1);
        @(negedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc_n);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed phases
    // ------------------------------------------------------------------
    initial begin
        int errs_a, errs_b, lost_a, lost_b, early_err, t;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
            m_sel[i] = 4'hF; txn[i] = 0; blen[i] = 1; bl[i] = 0; seen[i] = 1'b0;
        end
        m_adr[0] = 30'h100; m_dat[0] = 32'h1111_0000;
        m_adr[1] = 30'h200; m_dat[1] = 32'h2222_0000;
        s_rdat = 32'hD000_0000;
        ready  = 1'b1;
        rst    = 1'b0;

        // reset held with both masters requesting
        txn[0] = 1; txn[1] = 1;
        repeat (3) @(negedge clk);
        chk("reset_both_cyc_driven", {m_cyc[0], m_cyc[1]}, 2'b11);
        chk("reset_s_cyc", s_cyc[0], 1'b0);
        chk("reset_s_stb", s_stb[0], 1'b0);
        chk("reset_s_adr", s_adr[0], 30'h0);
        chk("reset_resp", {ack0[0], ack1[0], err0[0], err1[0]}, 4'b0000);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("first_grant_adr", s_adr[0], 30'h100);
        chk("first_grant_acks", {ack0[0], ack1[0]}, 2'b10);
        wait_idle("reset");

        // contention: 3 single-beat envelopes each
        ack_who.delete(); ack_when.delete();
        txn[0] = 3; txn[1] = 3;
        wait_idle("contention");
        chk("contention_count", ack_who.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("contention_order_%0d", i), (i < ack_who.size()) ? ack_who[i] : -1, i % 2);
        end
        for (int i = 1; i < 6; i++) begin
            chk($sformatf("contention_gap_%0d", i),
                (i < ack_when.size()) ? ack_when[i] - ack_when[i-1] : -1, 2);
        end

        // burst hold: m1 four beats, m0 requests one cycle later
        ack_who.delete(); ack_when.delete();
        blen[1] = 4; txn[1] = 1;
        @(negedge clk);
        #2 txn[0] = 1;
        wait_idle("burst");
        chk("burst_count", ack_who.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("burst_owner_%0d", i), (i < ack_who.size()) ? ack_who[i] : -1, (i < 4) ? 1 : 0);
        end
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("burst_gap_%0d", i),
                (i < ack_when.size()) ? ack_when[i] - ack_when[i-1] : -1, (i < 4) ? 1 : 2);
        end
        blen[1] = 1;

        // write path from m1
        m_we[1] = 1'b1; m_sel[1] = 4'b0101; m_dat[1] = 32'hA5A5_1234; m_adr[1] = 30'h2000_0010;
        m_we[0] = 1'b0;
        txn[1] = 1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ack1[0] && t < 20);
        chk("write_ack_seen", ack1[0], 1'b1);
        chk("write_slave_we", s_we[0], 1'b1);
        chk("write_slave_sel", s_sel[0], 4'b0101);
        chk("write_slave_dat", s_wdat[0], 32'hA5A5_1234);
        chk("write_slave_adr", s_adr[0], 30'h2000_0010);
        chk("write_slave_b", {s_we[1], s_sel[1], s_wdat[1], s_adr[1]},
            {1'b1, 4'b0101, 32'hA5A5_1234, 30'h2000_0010});
        wait_idle("write");
        m_we[1] = 1'b0; m_sel[1] = 4'hF; m_dat[1] = 32'h2222_0000; m_adr[1] = 30'h200;

        // watchdog: slave stalls m0 for 1000 strobe cycles
        ready = 1'b0;
        txn[0] = 1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!s_stb[0] && t < 20);
        chk("stall_strobe_seen", s_stb[0], 1'b1);
        errs_a = 0; errs_b = 0; lost_a = 0; lost_b = 0; early_err = 0;
        for (int k = 1; k <= 1000; k++) begin
            if (k > 1) @(negedge clk);
            if (k < 5 && err0[0]) early_err++;
            if (k == 5) begin
                chk("wd_err_5th", err0[0], 1'b1);
                chk("wd_stb_low_5th", s_stb[0], 1'b0);
            end
            if (err0[0]) errs_a++;
            if (err0[1]) errs_b++;
            if (!s_cyc[0]) lost_a++;
            if (!(s_cyc[1] && s_stb[1])) lost_b++;
        end
        chk("wd_no_early_err", early_err, 0);
        chk("wd_err_count", errs_a, 200);
        chk("wd_grant_held_a", lost_a, 0);
        chk("nowd_err_count", errs_b, 0);
        chk("nowd_grant_held", lost_b, 0);
        #2 ready = 1'b1;
        @(negedge clk);
        chk("wd_late_ack_a", {ack0[0], err0[0]}, 2'b10);
        chk("nowd_late_ack_b", {ack0[1], err0[1]}, 2'b10);
        wait_idle("watchdog");

        // reset asserted in the middle of an m1 transfer
        ready = 1'b0;
        txn[1] = 1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!s_cyc[0] && t < 20);
        chk("midreset_granted", s_cyc[0], 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("midreset_outputs_a", {s_cyc[0], s_stb[0], s_adr[0]}, 32'h0);
        chk("midreset_outputs_b", {s_cyc[1], s_stb[1], s_adr[1]}, 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        ready = 1'b1;
        wait_idle("midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
